mdu_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit: a state machine sequencing a one-bit-per-cycle shift-add multiplier and restoring divider over shared working registers. It sits in the EX stage beside the ALU. The main controller pulses `start` with decoded `func3`, holds in EX until `done`, then takes `result` into writeback.

---
 rtl/mdu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit. A five-state controller sequences a
// one-bit-per-cycle shift-add multiplier and a restoring divider. Both
// algorithms share one double-width working register: for multiply it holds
// {partial product, multiplier}; for divide it holds {remainder, dividend/quotient}.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [2:0]        op_lat;
    logic [XLEN-1:0]   a_lat, b_lat;
    logic [2*XLEN-1:0] work;       // shared product / remainder:quotient register
    logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt;
    logic              neg_main;   // product / quotient must be negated
    logic              neg_rem;    // remainder must be negated
    logic              divzero, ovf;

    // operand decode on the latched request
    logic is_mul, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        is_mul   = ~op_lat[2];
        a_signed = is_mul ? (op_lat[1:0] != 2'b11) : ~op_lat[0];
        b_signed = is_mul ? ~op_lat[1] : ~op_lat[0];
        a_neg    = a_signed & a_lat[XLEN-1];
        b_neg    = b_signed & b_lat[XLEN-1];
        mag_a    = a_neg ? (~a_lat + 1'b1) : a_lat;
        mag_b    = b_neg ? (~b_lat + 1'b1) : b_lat;
    end

    // one iteration of each algorithm, computed from the working register
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step;

    always_comb begin
        mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, (work[0] ? opnd : '0)};
        mul_step  = {mul_sum, work[XLEN-1:1]};
        div_shift = {work[2*XLEN-1:XLEN], work[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN])
            div_step = {div_diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
        else
            div_step = {div_shift[XLEN-1:0], work[XLEN-2:0], 1'b0};
    end

    // final sign correction and divide-corner overrides
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_value;

    always_comb begin
        prod_fix = neg_main ? (~work + 1'b1) : work;
        quo_fix  = neg_main ? (~work[XLEN-1:0] + 1'b1) : work[XLEN-1:0];
        rem_fix  = neg_rem ? (~work[2*XLEN-1:XLEN] + 1'b1) : work[2*XLEN-1:XLEN];
        fix_value = '0;
        case (op_lat)
            3'b000:                 fix_value = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_value = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_value = divzero ? '1 : (ovf ? a_lat : quo_fix);
            default:                fix_value = divzero ? a_lat : (ovf ? '0 : rem_fix);
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // next-state logic; the sequence length never depends on the operands
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_PREP;
            S_PREP:  state_next = S_CALC;
            S_CALC:  if (cnt == CNT_LAST) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy/done registered from the next state so they carry no input path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
        end
    end

    // datapath: capture request, prepare magnitudes, iterate, load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_lat   <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            work     <= '0;
            opnd     <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            divzero  <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_lat <= op;
                        a_lat  <= rs1;
                        b_lat  <= rs2;
                    end
                end
                S_PREP: begin
                    work     <= {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
                    opnd     <= is_mul ? mag_a : mag_b;
                    neg_main <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    divzero  <= (b_lat == '0);
                    ovf      <= ~is_mul & ~op_lat[0]
                                & (a_lat == {1'b1, {(XLEN-1){1'b0}}})
                                & (b_lat == '1);
                    cnt      <= '0;
                end
                S_CALC: begin
                    work <= is_mul ? mul_step : div_step;
                    cnt  <= cnt + 1'b1;
                end
                S_FIX: begin
                    result <= fix_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed RV32M cases, protocol and
// reset scenarios, then randomized ops against a 64-bit arithmetic model.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: RV32M semantics via wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // one full transaction: accept, scramble inputs, time done, check result
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit seen;
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd34);
        chk({tag, "_result"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        $display("op=%0d rs1=%h rs2=%h result=%h exp=%h lat=%0d", o, a, b, result, exp, lat);
    endtask

    initial begin
        int ndone;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed arithmetic
        do_op("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_neg",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        do_op("rem_neg",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        do_op("divu",       3'd5, 32'd100,        32'd7,         32'd14);
        do_op("remu",       3'd7, 32'd100,        32'd7,         32'd2);
        do_op("div_z",      3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
        do_op("rem_z",      3'd6, 32'd5,          32'd0,         32'd5);
        do_op("divu_z",     3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
        do_op("remu_z",     3'd7, 32'h1234,       32'd0,         32'h1234);
        do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // protocol: start during CALC and during DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; rs1 = $urandom; rs2 = $urandom;
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                chk("proto_result", result, 32'd12);
                start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
            end
        end
        start = 1'b0;
        chk("proto_done_count", 32'(ndone), 32'd1);
        chk("proto_hold", result, 32'd12);
        chk("proto_idle", {31'd0, busy}, 32'd0);
        $display("protocol: dones=%0d result=%h", ndone, result);

        // reset in the middle of CALC (iteration 10) aborts the op
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs1 = 32'd1234; rs2 = 32'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        ndone = 0;
        repeat (3) begin @(negedge clk); if (done) ndone++; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("abort_no_done", 32'(ndone), 32'd0);
        $display("reset abort: busy=%b done=%b result=%h", busy, done, result);
        do_op("post_rst_divu", 3'd5, 32'd9, 32'd3, 32'd3);

        // randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op("rand", ro, ra, rb, ref_model(ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
